// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM state encoding and strobe-width helper.
// Pure declarations; no timing or backpressure of its own.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    function automatic int APB_STRB_W(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_regfile_completer.sv
// APB4 word register file: NUM_REGS-1 byte-writable registers plus a read-only status word.
// Completes WAIT_CYCLES+1 cycles after setup; the requester is held off by pready only.
module apb_regfile_completer
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           pnse,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [DATA_WIDTH-1:0]          status_i
);

    localparam int STRB_W = APB_STRB_W(DATA_WIDTH);
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int SEL_W  = $clog2(NUM_REGS);
    localparam int LAST   = NUM_REGS - 1;

    apb_state_e            state;
    logic [3:0]            cnt;
    logic [SEL_W-1:0]      sel_q;
    logic                  wr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS-1];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic [SEL_W-1:0]      setup_sel;
    logic                  setup_err;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_apb;

    // Protection and security attributes carry no meaning for this block.
    assign unused_apb = ^{pprot, pnse};

    assign word_idx     = paddr >> OFF_W;
    assign misaligned   = |(paddr & ADDR_WIDTH'(STRB_W - 1));
    assign out_of_range = (word_idx >= ADDR_WIDTH'(NUM_REGS));
    assign setup_sel    = word_idx[SEL_W-1:0];

    // Errors are decided at setup, while the address phase is guaranteed stable.
    assign setup_err = out_of_range
                     | misaligned
                     | (pwrite && (setup_sel == SEL_W'(LAST)))
                     | (!pwrite && (|pstrb));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            cnt      <= '0;
            sel_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse <= '0;
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (psel && !penable) begin
                        sel_q <= setup_sel;
                        wr_q  <= pwrite;
                        err_q <= setup_err;
                        cnt   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state   <= RESP;
                            pready  <= 1'b1;
                            pslverr <= setup_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= RESP;
                            pready  <= 1'b1;
                            pslverr <= err_q;
                        end
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    // A requester that dropped psel has abandoned the transfer.
                    if (psel && wr_q && !err_q) begin
                        for (int k = 0; k < STRB_W; k++) begin
                            if (pstrb[k]) begin
                                regs[sel_q][k*8 +: 8] <= pwdata[k*8 +: 8];
                            end
                        end
                        wr_pulse[sel_q] <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

    assign rd_val = (sel_q == SEL_W'(LAST)) ? status_i : regs[sel_q];

    // Read data is live so the status word reflects the completion cycle itself.
    assign prdata = (state == RESP && pready && !wr_q && !err_q) ? rd_val : '0;

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg_q
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
    assign reg_q[LAST*DATA_WIDTH +: DATA_WIDTH] = status_i;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Directed bench: a zero-wait and a three-wait completer share one APB bus with separate selects.
module tb_apb_regfile_completer;

    logic         pclk = 1'b0;
    logic         presetn;
    logic [31:0]  paddr;
    logic [2:0]   pprot;
    logic         pnse;
    logic         psel_a, psel_b;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [31:0]  status_i;

    logic         pready_a, pready_b;
    logic [31:0]  prdata_a, prdata_b;
    logic         pslverr_a, pslverr_b;
    logic [255:0] reg_q_a, reg_q_b;
    logic [7:0]   wr_pulse_a, wr_pulse_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 pclk = ~pclk;

    apb_regfile_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(0)) u_dut_a (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .pnse(pnse),
        .psel(psel_a), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a),
        .reg_q(reg_q_a), .wr_pulse(wr_pulse_a), .status_i(status_i)
    );

    apb_regfile_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(3)) u_dut_b (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .pnse(pnse),
        .psel(psel_b), .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b),
        .reg_q(reg_q_b), .wr_pulse(wr_pulse_b), .status_i(status_i)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [255:0] q, input int i);
        return q[i*32 +: 32];
    endfunction

    // Caller is positioned 1 time unit after a rising edge; setup starts immediately.
    task automatic xfer(input bit use_b, input logic [31:0] addr, input bit wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err, output int waits,
                        output logic [7:0] pulse, output bit err_early);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        penable = 1'b0;
        if (use_b) psel_b = 1'b1; else psel_a = 1'b1;
        @(posedge pclk); #1;
        penable   = 1'b1;
        waits     = 0;
        err_early = 1'b0;
        while (!(use_b ? pready_b : pready_a) && waits < 40) begin
            if (use_b ? pslverr_b : pslverr_a) err_early = 1'b1;
            @(posedge pclk); #1;
            waits++;
        end
        rdata = use_b ? prdata_b : prdata_a;
        err   = use_b ? pslverr_b : pslverr_a;
        @(posedge pclk); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pulse   = use_b ? wr_pulse_b : wr_pulse_a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd;
        logic         er;
        int           wt;
        logic [7:0]   pl;
        bit           ee;
        logic [223:0] exp_rw;

        presetn = 1'b0; paddr = '0; pprot = 3'b010; pnse = 1'b1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = '0; pstrb = '0; status_i = '0;

        #12;
        chk("rst_pready_a", pready_a, 0);
        chk("rst_pslverr_a", pslverr_a, 0);
        chk("rst_prdata_a", prdata_a, 0);
        chk("rst_reg_q_a", reg_q_a, 0);
        chk("rst_wr_pulse_a", wr_pulse_a, 0);
        chk("rst_pready_b", pready_b, 0);
        @(posedge pclk); #1; presetn = 1'b1;
        @(posedge pclk); #1;

        xfer(0, 32'h4, 1, 32'hA5A5_1234, 4'hF, rd, er, wt, pl, ee);
        chk("wr_full_waits", wt, 0);
        chk("wr_full_err", er, 0);
        chk("wr_full_pulse", pl, 8'h02);
        chk("wr_full_reg1", word(reg_q_a, 1), 32'hA5A5_1234);
        @(posedge pclk); #1;
        chk("wr_pulse_one_cycle", wr_pulse_a, 0);

        xfer(0, 32'h4, 1, 32'hFFFF_FFFF, 4'h2, rd, er, wt, pl, ee);
        chk("wr_byte1_err", er, 0);
        chk("wr_byte1_reg1", word(reg_q_a, 1), 32'hA5A5_FF34);

        xfer(1, 32'h4, 1, 32'hA5A5_1234, 4'hF, rd, er, wt, pl, ee);
        xfer(1, 32'h4, 1, 32'hFFFF_FFFF, 4'h2, rd, er, wt, pl, ee);
        xfer(1, 32'h4, 0, 32'h0, 4'h0, rd, er, wt, pl, ee);
        chk("wait3_waits", wt, 3);
        chk("wait3_rdata", rd, 32'hA5A5_FF34);
        chk("wait3_err", er, 0);
        chk("wait3_no_early_err", ee, 0);

        xfer(0, 32'h40, 0, 32'h0, 4'h0, rd, er, wt, pl, ee);
        chk("oor_err", er, 1);
        chk("oor_rdata", rd, 0);
        xfer(0, 32'h6, 0, 32'h0, 4'h0, rd, er, wt, pl, ee);
        chk("misalign_err", er, 1);
        chk("misalign_rdata", rd, 0);
        xfer(0, 32'h1C, 1, 32'h1234_5678, 4'hF, rd, er, wt, pl, ee);
        chk("ro_wr_err", er, 1);
        chk("ro_wr_pulse", pl, 0);
        xfer(0, 32'h4, 0, 32'h0, 4'h1, rd, er, wt, pl, ee);
        chk("rd_strb_err", er, 1);
        chk("rd_strb_rdata", rd, 0);
        exp_rw = '0;
        exp_rw[63:32] = 32'hA5A5_FF34;
        chk("err_regs_unchanged", reg_q_a[223:0], exp_rw);

        xfer(0, 32'h0, 1, 32'h1234_5678, 4'hF, rd, er, wt, pl, ee);
        chk("b2b_wr_pulse", pl, 8'h01);
        xfer(0, 32'h0, 0, 32'h0, 4'h0, rd, er, wt, pl, ee);
        chk("b2b_rd_waits", wt, 0);
        chk("b2b_rd_rdata", rd, 32'h1234_5678);
        status_i = 32'hDEAD_BEEF;
        xfer(0, 32'h1C, 0, 32'h0, 4'h0, rd, er, wt, pl, ee);
        chk("status_rdata", rd, 32'hDEAD_BEEF);
        chk("status_err", er, 0);

        paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h55AA_55AA; pstrb = 4'hF;
        penable = 1'b0; psel_b = 1'b1;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1; psel_b = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        chk("abort_pready", pready_b, 0);
        chk("abort_wr_pulse", wr_pulse_b, 0);
        @(posedge pclk); #1;
        chk("abort_reg2", word(reg_q_b, 2), 0);
        xfer(1, 32'h8, 0, 32'h0, 4'h0, rd, er, wt, pl, ee);
        chk("post_abort_waits", wt, 3);
        chk("post_abort_rdata", rd, 0);

        paddr = 32'h4; pwrite = 1'b1; pwdata = 32'h1111_1111; pstrb = 4'hF;
        penable = 1'b0; psel_b = 1'b1;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1; presetn = 1'b0;
        #1;
        chk("rst_mid_pready", pready_b, 0);
        chk("rst_mid_reg1", word(reg_q_b, 1), 0);
        psel_b = 1'b0; penable = 1'b0;
        @(posedge pclk); #1; presetn = 1'b1;
        @(posedge pclk); #1;
        chk("rst_mid_wr_pulse", wr_pulse_b, 0);
        chk("rst_mid_reg1_after", word(reg_q_b, 1), 0);
        xfer(1, 32'h4, 0, 32'h0, 4'h0, rd, er, wt, pl, ee);
        chk("post_rst_waits", wt, 3);
        chk("post_rst_rdata", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_regfile_completer.md
APB_REGFILE_COMPLETER -- requirements
Module: apb_regfile_completer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the APB data width (multiple of 8).
REQ-003 SHALL have parameter NUM_REGS, default 8, the number of word registers (2..256).
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, the number of access-phase wait states inserted before pready (0..15).
REQ-005 SHALL have port pclk, input, 1, the clock; all state is on the rising edge.
REQ-006 SHALL have port presetn, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have inputs paddr (ADDR_WIDTH), pprot (3), pnse (1), psel (1), penable (1), pwrite (1), pwdata (DATA_WIDTH) and pstrb (DATA_WIDTH/8), carrying the APB4 requester signals.
REQ-008 SHALL have outputs pready (1), prdata (DATA_WIDTH) and pslverr (1), carrying the APB completer response.
REQ-009 SHALL have output reg_q, NUM_REGS*DATA_WIDTH wide, giving the flattened register contents, with register i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have output wr_pulse, NUM_REGS wide, giving a one-cycle commit strobe per register.
REQ-011 SHALL have input status_i, DATA_WIDTH wide, giving the hardware value returned for register NUM_REGS-1.

Function
REQ-012 SHALL decode a word index as paddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] and treat the low byte-offset bits as alignment bits.
REQ-013 SHALL implement registers 0..NUM_REGS-2 as read/write, and register NUM_REGS-1 as read-only returning status_i.
REQ-014 SHALL use a state machine with states IDLE, WAIT and RESP.
REQ-015 IDLE: on psel=1 and penable=0, SHALL capture the address and the error condition, load the counter with WAIT_CYCLES, and go to RESP with pready<=1 if WAIT_CYCLES=0, otherwise go to WAIT.
REQ-016 WAIT: SHALL decrement the counter each cycle; when the counter is 1, SHALL set pready<=1 and go to RESP. Zero wait states therefore put pready high in the first access cycle.
REQ-017 RESP: pready SHALL be high for exactly one cycle (the completion cycle); the state machine SHALL then return to IDLE with pready<=0, so a back-to-back setup in the following cycle is accepted.
REQ-018 pslverr SHALL be 1 during the completion cycle if any of the following holds: the index is >= NUM_REGS; the alignment bits are nonzero; pwrite=1 targets register NUM_REGS-1; or pwrite=0 with pstrb!=0.
REQ-019 A write SHALL commit at the completion edge only when pslverr=0, updating byte k of the target where pstrb[k]=1; wr_pulse[index] SHALL be high for the following cycle.
REQ-020 During the completion cycle of a read, prdata SHALL equal the register value (status_i sampled that cycle for the last register), or 0 on error; prdata SHALL be 0 in all other cycles.
REQ-021 pslverr SHALL be 0 whenever pready=0.
REQ-022 If psel falls while in WAIT or RESP (protocol abort), the block SHALL return to IDLE next cycle with no write, no wr_pulse, and pready=0.
REQ-023 pprot and pnse SHALL be ignored.

Reset
REQ-024 On presetn=0, asynchronously: state=IDLE, counter=0, pready=0, pslverr=0, prdata=0, all registers=0, wr_pulse=0.
REQ-025 Reset asserted mid-transfer SHALL discard the transfer; no partial byte update SHALL occur.

Structure
REQ-026 Package apb_pkg SHALL hold the completer state enum (IDLE/WAIT/RESP) and the constant APB_STRB_W function (DATA_WIDTH/8).
REQ-027 The register array, decode and FSM SHALL reside in one module; no sub-module is required.

Verification
REQ-028 Write 0xA5A5_1234 to 0x4 with pstrb=0xF and WAIT_CYCLES=0 -> pready high in the first access cycle, pslverr=0, reg 1 = 0xA5A5_1234, wr_pulse[1] for one cycle.
REQ-029 Write 0xFFFF_FFFF to 0x4 with pstrb=0x2 after REQ-028 -> reg 1 = 0xA5A5_FF34.
REQ-030 With WAIT_CYCLES=3, read 0x4 -> pready low for 3 access cycles, then high for one cycle with prdata=0xA5A5_FF34.
REQ-031 Read 0x40 (index 16 >= 8), read 0x6 (misaligned), and write 0x1C (read-only) -> pslverr=1 with prdata=0 on each, registers unchanged.
REQ-032 Back-to-back write/read to 0x0, and status_i=0xDEAD_BEEF read at 0x1C -> no idle cycle required between transfers, and the read returns 0xDEAD_BEEF.
REQ-033 Drop psel in WAIT, and assert presetn=0 mid-write -> FSM returns to IDLE, and no register changes.
